// File: rtl/mps_intl_latch.sv
// mps_intl_latch: synchronise, debounce, mask and latch the 23 MPS interlock sources
module mps_intl_latch #(
  parameter int DB_CYCLES = 200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [16:0] i_analog_intl,
  input  logic [15:0] i_ext_di,
  input  logic [22:0] i_intl_mask,
  input  logic        i_intl_clr,
  output logic        o_intl_flag,
  output logic [22:0] o_intl_state,
  output logic [22:0] o_intl_raw,
  output logic [4:0]  o_first_fault,
  output logic        o_first_valid,
  output logic        o_clr_fail,
  output logic [15:0] o_trip_cnt
);
  localparam int N = 23;
  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);
  logic [N-1:0] src, s1, s2, db, act, fresh;
  logic [15:0]  cnt [N];
  logic         accept;
  logic [4:0]   first_idx;
  logic         unused_di;
  assign src       = {i_ext_di[8:4], i_ext_di[0], i_analog_intl};
  assign unused_di = ^{i_ext_di[15:9], i_ext_di[3:1]};
  assign act       = db & ~i_intl_mask;
  // a live unmasked trip always beats a clear issued in the same cycle
  assign accept    = i_intl_clr && act == '0;
  assign fresh     = act & ~o_intl_state;
  always_comb begin
    first_idx = '0;
    for (int i = N - 1; i >= 0; i--) first_idx = fresh[i] ? 5'(i) : first_idx;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= src;
      s2 <= s1;
      for (int i = 0; i < N; i++) begin
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == DB_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_intl_raw    <= '0;
      o_intl_state  <= '0;
      o_intl_flag   <= 1'b0;
      o_first_fault <= '0;
      o_first_valid <= 1'b0;
      o_clr_fail    <= 1'b0;
      o_trip_cnt    <= '0;
    end else begin
      o_intl_raw    <= db;
      o_intl_state  <= accept ? '0 : o_intl_state | act;
      o_first_valid <= accept ? 1'b0 : o_first_valid | (|fresh);
      if (!accept && !o_first_valid && |fresh) o_first_fault <= first_idx;
      o_clr_fail    <= i_intl_clr && !accept;
      o_intl_flag   <= |o_intl_state;
      if (|o_intl_state && !o_intl_flag && o_trip_cnt != 16'hFFFF) o_trip_cnt <= o_trip_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_mps_intl_latch.sv
// tb_mps_intl_latch: directed and random checks of mps_intl_latch against a window-based model
module tb_mps_intl_latch;
  localparam int DB = 4;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [16:0] i_analog_intl = '0;
  logic [15:0] i_ext_di = '0;
  logic [22:0] i_intl_mask = '0;
  logic        i_intl_clr = 1'b0;
  logic        o_intl_flag;
  logic [22:0] o_intl_state;
  logic [22:0] o_intl_raw;
  logic [4:0]  o_first_fault;
  logic        o_first_valid;
  logic        o_clr_fail;
  logic [15:0] o_trip_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  mps_intl_latch #(.DB_CYCLES(DB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_analog_intl(i_analog_intl), .i_ext_di(i_ext_di),
    .i_intl_mask(i_intl_mask), .i_intl_clr(i_intl_clr), .o_intl_flag(o_intl_flag),
    .o_intl_state(o_intl_state), .o_intl_raw(o_intl_raw), .o_first_fault(o_first_fault),
    .o_first_valid(o_first_valid), .o_clr_fail(o_clr_fail), .o_trip_cnt(o_trip_cnt)
  );
  always #5 i_clk = ~i_clk;
  // model: history of sampled source vectors; a level flips once the last DB
  // synchronised samples all disagree with it
  logic [22:0] hist[$];
  logic [22:0] m_db, m_raw, m_state;
  logic        m_flag, m_fv, m_clr_fail;
  logic [4:0]  m_ff;
  logic [15:0] m_cnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    hist = {};
    hist.push_back('0);
    hist.push_back('0);
    m_db = '0; m_raw = '0; m_state = '0; m_flag = 0; m_fv = 0; m_clr_fail = 0; m_ff = '0; m_cnt = '0;
  endtask
  task automatic model_edge();
    logic [22:0] act, fresh, nd;
    logic        accept, all_diff;
    int          sz;
    hist.push_back({i_ext_di[8:4], i_ext_di[0], i_analog_intl});
    if (hist.size() > DB + 3) void'(hist.pop_front());
    sz = hist.size();
    nd = m_db;
    if (sz >= DB + 2)
      for (int i = 0; i < 23; i++) begin
        all_diff = 1;
        for (int k = 0; k < DB; k++) if (hist[sz - 3 - k][i] == m_db[i]) all_diff = 0;
        if (all_diff) nd[i] = ~m_db[i];
      end
    act = m_db & ~i_intl_mask;
    accept = i_intl_clr && act == 0;
    fresh = act & ~m_state;
    if (!accept && !m_fv && fresh != 0) begin
      for (int i = 22; i >= 0; i--) if (fresh[i]) m_ff = 5'(i);
      m_fv = 1;
    end
    if (accept) m_fv = 0;
    m_clr_fail = i_intl_clr && !accept;
    if (m_state != 0 && !m_flag && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    m_flag = m_state != 0;
    m_raw = m_db;
    m_state = accept ? '0 : m_state | act;
    m_db = nd;
  endtask
  task automatic cyc();
    model_edge();
    @(posedge i_clk);
    #1;
    chk("state", 32'(o_intl_state), 32'(m_state));
    chk("raw", 32'(o_intl_raw), 32'(m_raw));
    chk("flag", 32'(o_intl_flag), 32'(m_flag));
    chk("first_fault", 32'(o_first_fault), 32'(m_ff));
    chk("first_valid", 32'(o_first_valid), 32'(m_fv));
    chk("clr_fail", 32'(o_clr_fail), 32'(m_clr_fail));
    chk("trip_cnt", 32'(o_trip_cnt), 32'(m_cnt));
  endtask
  task automatic settle(input int n);
    repeat (n) cyc();
  endtask
  task automatic clear();
    i_intl_clr = 1;
    cyc();
    i_intl_clr = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(o_intl_state), 0);
    chk({tag, "_raw"}, 32'(o_intl_raw), 0);
    chk({tag, "_flag"}, 32'(o_intl_flag), 0);
    chk({tag, "_ff"}, 32'(o_first_fault), 0);
    chk({tag, "_fv"}, 32'(o_first_valid), 0);
    chk({tag, "_clr_fail"}, 32'(o_clr_fail), 0);
    chk({tag, "_cnt"}, 32'(o_trip_cnt), 0);
  endtask
  initial begin
    logic [22:0] v;
    int idx;
    repeat (3) @(posedge i_clk);
    #1;
    chk_zero("rst");
    @(negedge i_clk);
    i_rst = 1;
    model_reset();
    // source 3: latch at edge DB+3, flag at DB+4
    i_analog_intl[3] = 1;
    settle(DB + 2);
    chk("t1_no_latch_yet", 32'(o_intl_state), 0);
    cyc();
    chk("t1_state_e7", 32'(o_intl_state), 32'h8);
    chk("t1_flag_e7", 32'(o_intl_flag), 0);
    cyc();
    chk("t1_flag_e8", 32'(o_intl_flag), 1);
    chk("t1_ff", 32'(o_first_fault), 3);
    chk("t1_fv", 32'(o_first_valid), 1);
    chk("t1_cnt", 32'(o_trip_cnt), 1);
    i_analog_intl[3] = 0;
    settle(DB + 4);
    clear();
    chk("t1_clr_state", 32'(o_intl_state), 0);
    chk("t1_clr_fv", 32'(o_first_valid), 0);
    chk("t1_clr_flag_hold", 32'(o_intl_flag), 1);
    cyc();
    chk("t1_clr_flag_fall", 32'(o_intl_flag), 0);
    // ext_di[0]: 3-cycle pulse filtered, 4-cycle pulse latches source 17
    i_ext_di[0] = 1;
    settle(DB - 1);
    i_ext_di[0] = 0;
    settle(DB + 6);
    chk("t2_short_state", 32'(o_intl_state), 0);
    chk("t2_short_flag", 32'(o_intl_flag), 0);
    i_ext_di[0] = 1;
    settle(DB);
    i_ext_di[0] = 0;
    settle(DB + 6);
    chk("t2_long_state", 32'(o_intl_state), 32'h20000);
    clear();
    // clear rejected while source 5 is live
    i_analog_intl[5] = 1;
    settle(DB + 5);
    clear();
    chk("t3_clr_fail", 32'(o_clr_fail), 1);
    chk("t3_state_kept", 32'(o_intl_state), 32'h20);
    cyc();
    chk("t3_clr_fail_pulse", 32'(o_clr_fail), 0);
    i_analog_intl[5] = 0;
    settle(DB + 4);
    clear();
    chk("t3_clr_ok", 32'(o_intl_state), 0);
    // mask source 20, then unmask
    i_intl_mask[20] = 1;
    i_ext_di[6] = 1;
    settle(DB + 6);
    chk("t4_masked_state", 32'(o_intl_state), 0);
    chk("t4_raw20", 32'(o_intl_raw[20]), 1);
    i_intl_mask[20] = 0;
    cyc();
    chk("t4_unmasked", 32'(o_intl_state), 32'h100000);
    i_ext_di[6] = 0;
    settle(DB + 4);
    clear();
    // simultaneous sources 10 and 2, then source 0 later
    i_analog_intl[10] = 1;
    i_analog_intl[2] = 1;
    settle(DB + 5);
    chk("t5_ff", 32'(o_first_fault), 2);
    chk("t5_state", 32'(o_intl_state), 32'h404);
    i_analog_intl[0] = 1;
    settle(DB + 5);
    chk("t5_ff_kept", 32'(o_first_fault), 2);
    chk("t5_state0", 32'(o_intl_state), 32'h405);
    i_analog_intl = '0;
    settle(DB + 4);
    clear();
    // async reset while latched and mid-debounce
    i_analog_intl[7] = 1;
    settle(DB + 5);
    i_analog_intl[9] = 1;
    settle(2);
    #2 i_rst = 0;
    #1;
    chk_zero("arst");
    model_reset();
    @(negedge i_clk);
    i_rst = 1;
    settle(DB + 2);
    chk("t6_no_latch_yet", 32'(o_intl_state), 0);
    cyc();
    chk("t6_relatch", 32'(o_intl_state), 32'h280);
    chk("t6_ff", 32'(o_first_fault), 7);
    i_analog_intl = '0;
    settle(DB + 4);
    clear();
    // random phase
    v = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idx = $urandom_range(0, 22);
        v[idx] = ($urandom_range(0, 3) == 0);
      end
      i_analog_intl = v[16:0];
      i_ext_di = 16'($urandom);
      i_ext_di[0] = v[17];
      i_ext_di[8:4] = v[22:18];
      if ($urandom_range(0, 60) == 0) i_intl_mask = 23'($urandom) & 23'($urandom);
      i_intl_clr = ($urandom_range(0, 12) == 0);
      cyc();
    end
    i_intl_clr = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mps_intl_latch.md
# mps_intl_latch

Interlock qualification stage for the MPS. It sits directly upstream of the MPS system FSM and operation FSM and drives their interlock input. It synchronises and debounces 23 raw interlock sources (17 analog comparators, 6 external digital inputs), applies a software mask, and latches trips until software clears them. It also records the first fault and counts trip events for AXI readback.

## Interface
- DB_CYCLES, 200, number of consecutive identical samples before a debounced level changes (1 µs at 200 MHz); legal range 1..65535.
- i_clk  in  1  system clock (200 MHz domain).
- i_rst  in  1  reset; one clock; reset is asynchronous and active-low.
- i_analog_intl  in  17  raw analog interlock comparators, asynchronous; source index 0..16 = bit 0..16.
- i_ext_di  in  16  raw external digital inputs, asynchronous; bit 0 → source 17, bits 8:4 → sources 22:18; other bits ignored.
- i_intl_mask  in  23  1 = source masked (never latches); quasi-static AXI register.
- i_intl_clr  in  1  clear request, one-cycle pulse from AXI.
- o_intl_flag  out  1  registered OR of all latched bits; feeds both FSMs.
- o_intl_state  out  23  latched trip bits per source.
- o_intl_raw  out  23  debounced, unmasked, unlatched source levels (for readback).
- o_first_fault  out  5  index of the first source to latch since the last clear.
- o_first_valid  out  1  o_first_fault holds a valid capture.
- o_clr_fail  out  1  one-cycle pulse: clear rejected.
- o_trip_cnt  out  16  count of o_intl_flag 0→1 transitions; saturates at 0xFFFF.

## Operation
- Reset values: all outputs 0. Sync flops, debounce counters, and debounced levels are 0.
- Per source, the raw input passes through a 2-flop synchroniser (s1, s2).
- Debounce, per source, with a 16-bit counter cnt and a level db. Each edge:
  - if s2 == db: cnt ← 0;
  - else if cnt == DB_CYCLES-1: db ← s2 and cnt ← 0;
  - else cnt ← cnt+1.
- Debounce is symmetric: both assertion and deassertion are filtered. A pulse shorter than DB_CYCLES samples has no effect.
- o_intl_raw = db vector (registered).
- Latch: state[i] ← state[i] | (db[i] & ~mask[i]) each edge. A latched bit is only cleared by an accepted clear or by reset. Masking an already latched bit does not clear it.
- First fault: capture only when o_first_valid == 0 and at least one state bit sets in this cycle. o_first_fault ← lowest newly set index; o_first_valid ← 1. Later trips do not overwrite the capture.
- Clear (i_intl_clr == 1):
  - Accepted if (db & ~mask) == 0 in that cycle. Then state ← 0 and o_first_valid ← 0. o_first_fault holds its old value but is invalid.
  - Otherwise rejected: state unchanged and o_clr_fail = 1 for one cycle.
- Clear and new debounced trip in the same cycle: trip wins. The clear is rejected and o_clr_fail pulses.
- o_intl_flag ← |state (registered, one cycle after state).
- o_trip_cnt increments on each cycle where the next flag is 1 and the current flag is 0. It saturates at 0xFFFF and is cleared only by reset.

## Timing
- Input change first sampled at edge 1 → s2 updated at edge 2 → db changes at edge DB_CYCLES+2 → o_intl_state/o_intl_raw at DB_CYCLES+3 → o_intl_flag at edge DB_CYCLES+4.
- Clear is accepted at the edge sampling i_intl_clr. o_intl_state reads 0 after that edge; o_intl_flag falls one edge later.
- o_clr_fail goes high the edge after i_intl_clr is sampled, for exactly one cycle.
- Reset mid-debounce or while latched: everything returns to 0 immediately (asynchronously). The debounce restarts from cnt = 0.
- Multiple sources whose db rises on the same edge latch together; first fault = lowest index.

## Test plan
- DB_CYCLES=4; hold i_analog_intl[3]=1 → o_intl_state[3]=1 at edge 7, o_intl_flag=1 at edge 8, o_first_fault=3, o_first_valid=1, o_trip_cnt=1.
- DB_CYCLES=4; 3-cycle pulse on i_ext_di[0] → no state change, o_intl_flag stays 0. Then a 4-cycle pulse → o_intl_state[17]=1.
- Trip source 5, release it, wait ≥ DB_CYCLES+3, pulse i_intl_clr → o_intl_state=0, o_first_valid=0, o_intl_flag falls next edge. Clear while source 5 is still high → o_clr_fail one-cycle pulse, state unchanged.
- i_intl_mask[20]=1, assert i_ext_di[6] → no latch, o_intl_raw[20]=1. Then unmask → latches after one edge.
- Sources 10 and 2 debounce on the same edge → o_first_fault=2. Source 0 tripping later leaves o_first_fault=2.
- Assert i_rst low while latched and mid-debounce → all outputs 0 immediately. After release, a held input re-latches after the full DB_CYCLES+3 latency.
